// File: rtl/core_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package core_pkg;

    localparam logic [31:0] NOP             = 32'h0000_0013;
    localparam int unsigned WAIT_STATES_DEF = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } imem_state_e;

endpackage

// File: rtl/imem_responder.sv
// Memory-side end of the fetch REQ/GNT handshake: one SRAM read, optional wait states, one-cycle grant.
// Define IMEM_ERR_EN to add o_INSTRUCTION_ERR and fault misaligned / out-of-range addresses.
module imem_responder
    import core_pkg::*;
#(
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_INSTRUCTION_REQ,
    input  logic [31:0]           i_INSTRUCTION_ADDR,
    output logic                  o_INSTRUCTION_GNT,
    output logic [31:0]           o_INSTRUCTION,
    output logic                  o_MEM_CE,
    output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
`ifdef IMEM_ERR_EN
    output logic                  o_INSTRUCTION_ERR,
`endif
    input  logic [31:0]           i_MEM_RDATA
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    imem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            cnt_q;
    logic [31:0]           rdata_q;
    logic [31:0]           instr_q;
    logic                  err_q;
    logic                  addr_bad;

`ifdef IMEM_ERR_EN
    assign addr_bad = (|i_INSTRUCTION_ADDR[1:0]) ||
                      ((i_INSTRUCTION_ADDR >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    // Low bits and upper aliasing bits are deliberately ignored in this build.
    logic addr_unused;
    assign addr_unused = ^{i_INSTRUCTION_ADDR[31:ADDR_WIDTH+2], i_INSTRUCTION_ADDR[1:0]};
    assign addr_bad    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_INSTRUCTION_REQ)
                    state_d = addr_bad ? ST_RESP : ST_READ;
            end
            ST_READ: begin
                state_d = i_INSTRUCTION_REQ ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
                if (!i_INSTRUCTION_REQ)
                    state_d = ST_IDLE;
                else
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                if (!i_INSTRUCTION_REQ)
                    state_d = ST_IDLE;
                else if (cnt_q == 4'd0)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= NOP;
            instr_q <= NOP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_IDLE) && (state_d == ST_RESP);

            if (state_q == ST_IDLE && i_INSTRUCTION_REQ && !addr_bad)
                addr_q <= i_INSTRUCTION_ADDR[ADDR_WIDTH+1:2];

            if (state_q == ST_CAPTURE)
                cnt_q <= WAIT_LOAD;
            else if (state_q == ST_WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;

            if (state_q == ST_CAPTURE && i_INSTRUCTION_REQ)
                rdata_q <= i_MEM_RDATA;

            // The visible word only changes when a grant is actually issued,
            // so an aborted fetch never disturbs o_INSTRUCTION.
            if (state_d == ST_RESP) begin
                if (state_q == ST_CAPTURE)
                    instr_q <= i_MEM_RDATA;
                else if (state_q == ST_WAIT)
                    instr_q <= rdata_q;
                else
                    instr_q <= NOP;
            end
        end
    end

    assign o_MEM_CE          = (state_q == ST_READ);
    assign o_MEM_ADDR        = addr_q;
    assign o_INSTRUCTION_GNT = (state_q == ST_RESP);
    assign o_INSTRUCTION     = instr_q;
`ifdef IMEM_ERR_EN
    assign o_INSTRUCTION_ERR = err_q;
`else
    logic err_unused;
    assign err_unused = err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with WAIT_STATES=0, one with WAIT_STATES=3.
module tb_imem_responder;

    localparam int AW = 10;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, req3 = 1'b0;
    logic [31:0]   addr0 = '0, addr3 = '0;
    logic          gnt0, gnt3, ce0, ce3, err0, err3;
    logic [31:0]   instr0, instr3, rdata0, rdata3;
    logic [AW-1:0] maddr0, maddr3;

    int checks = 0;
    int errors = 0;
    int ce_cnt0 = 0;

    function automatic logic [31:0] word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
    endfunction

    logic [31:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = word(i);

    always @(posedge clk) begin
        if (ce0) rdata0 <= mem[maddr0];
        if (ce3) rdata3 <= mem[maddr3];
        if (ce0) ce_cnt0 <= ce_cnt0 + 1;
    end

    imem_responder #(.WAIT_STATES(0), .ADDR_WIDTH(AW)) dut0 (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_INSTRUCTION_REQ(req0), .i_INSTRUCTION_ADDR(addr0),
        .o_INSTRUCTION_GNT(gnt0), .o_INSTRUCTION(instr0),
        .o_MEM_CE(ce0), .o_MEM_ADDR(maddr0),
`ifdef IMEM_ERR_EN
        .o_INSTRUCTION_ERR(err0),
`endif
        .i_MEM_RDATA(rdata0)
    );

    imem_responder #(.WAIT_STATES(3), .ADDR_WIDTH(AW)) dut3 (
        .i_CLK(clk), .i_RSTn(rst_n),
        .i_INSTRUCTION_REQ(req3), .i_INSTRUCTION_ADDR(addr3),
        .o_INSTRUCTION_GNT(gnt3), .o_INSTRUCTION(instr3),
        .o_MEM_CE(ce3), .o_MEM_ADDR(maddr3),
`ifdef IMEM_ERR_EN
        .o_INSTRUCTION_ERR(err3),
`endif
        .i_MEM_RDATA(rdata3)
    );

`ifndef IMEM_ERR_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic [31:0] a);
        if (d == 0) begin req0 = r; addr0 = a; end
        else        begin req3 = r; addr3 = a; end
    endtask

    function automatic logic get_gnt(input int d);
        return (d == 0) ? gnt0 : gnt3;
    endfunction

    // Called at a falling edge, which becomes cycle 0 of the request.
    task automatic txn(input int d, input logic [31:0] a, input int lat,
                       input logic [31:0] exp, input logic exp_err, input string tag);
        int  n = 0;
        bit  got = 0;
        drive(d, 1'b1, a);
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (get_gnt(d)) got = 1;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " data"}, (d == 0) ? instr0 : instr3, exp);
`ifdef IMEM_ERR_EN
        check({tag, " err"}, 32'((d == 0) ? err0 : err3), 32'(exp_err));
`else
        if (exp_err) check({tag, " err unexpected"}, 32'(exp_err), 32'd0);
`endif
        drive(d, 1'b0, a);
        @(negedge clk);
        check({tag, " gnt one cycle"}, 32'(get_gnt(d)), 32'd0);
    endtask

    initial begin
        int n;
        bit got;
        int base;

        repeat (3) @(negedge clk);
        check("rst gnt0", 32'(gnt0), 32'd0);
        check("rst ce0", 32'(ce0), 32'd0);
        check("rst maddr0", 32'(maddr0), 32'd0);
        check("rst instr0", instr0, NOP_W);
        check("rst err0", 32'(err0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic timing on WAIT_STATES=0.
        drive(0, 1'b1, 32'h0000_0010);
        check("t1 c0 ce", 32'(ce0), 32'd0);
        @(negedge clk);
        check("t1 c1 ce", 32'(ce0), 32'd1);
        check("t1 c1 maddr", 32'(maddr0), 32'd4);
        check("t1 c1 gnt", 32'(gnt0), 32'd0);
        @(negedge clk);
        check("t1 c2 ce", 32'(ce0), 32'd0);
        check("t1 c2 gnt", 32'(gnt0), 32'd0);
        check("t1 c2 instr held", instr0, NOP_W);
        @(negedge clk);
        check("t1 c3 gnt", 32'(gnt0), 32'd1);
        check("t1 c3 instr", instr0, 32'hDEAD_BEEF);
        drive(0, 1'b0, 32'h0000_0010);
        @(negedge clk);
        check("t1 c4 gnt", 32'(gnt0), 32'd0);
        check("t1 c4 instr hold", instr0, 32'hDEAD_BEEF);

        // Three wait states.
        txn(3, 32'h0000_0014, 6, word(5), 1'b0, "ws3");

        // Abort during WAIT: no grant, word unchanged, next request normal.
        drive(3, 1'b1, 32'h0000_0018);
        repeat (4) @(negedge clk);
        check("abort c4 gnt", 32'(gnt3), 32'd0);
        drive(3, 1'b0, 32'h0000_0018);
        @(negedge clk);
        check("abort c5 gnt", 32'(gnt3), 32'd0);
        check("abort c5 ce", 32'(ce3), 32'd0);
        @(negedge clk);
        check("abort c6 gnt", 32'(gnt3), 32'd0);
        check("abort c6 instr", instr3, word(5));
        txn(3, 32'h0000_0018, 6, word(6), 1'b0, "after abort");

        // Asynchronous reset while in WAIT.
        drive(3, 1'b1, 32'h0000_001C);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst gnt", 32'(gnt3), 32'd0);
        check("arst ce", 32'(ce3), 32'd0);
        check("arst instr", instr3, NOP_W);
        check("arst maddr", 32'(maddr3), 32'd0);
        drive(3, 1'b0, 32'h0000_001C);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst no gnt", 32'(gnt3), 32'd0);
        txn(3, 32'h0000_0020, 6, word(8), 1'b0, "post reset");

        // Sequential fetch stream, REQ held high, one grant every 4 cycles.
        drive(0, 1'b1, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            got = 0;
            while (n < 40 && !got) begin
                @(negedge clk);
                n++;
                if (gnt0) got = 1;
            end
            check($sformatf("stream%0d gap", i), 32'(n), (i == 0) ? 32'd3 : 32'd4);
            check($sformatf("stream%0d data", i), instr0, word(i));
            drive(0, (i < 7), 32'((i + 1) * 4));
        end
        @(negedge clk);
        check("stream end gnt", 32'(gnt0), 32'd0);

`ifdef IMEM_ERR_EN
        base = ce_cnt0;
        txn(0, 32'h0000_0002, 1, NOP_W, 1'b1, "err misalign");
        txn(0, 32'h0001_0000, 1, NOP_W, 1'b1, "err range");
        check("err no ce", 32'(ce_cnt0), 32'(base));
        txn(0, 32'h0000_0010, 3, 32'hDEAD_BEEF, 1'b0, "err recover");
`else
        base = ce_cnt0;
        txn(0, 32'h0000_1010, 3, 32'hDEAD_BEEF, 1'b0, "alias");
        check("alias ce once", 32'(ce_cnt0), 32'(base + 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
